// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion logic: state encoding, default resolution
// and comparator polarity.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRIAL  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_t;

    localparam int DEFAULT_N_BITS = 16;

    // Comparator level meaning Vin >= Vdac, i.e. the trial bit is kept.
    localparam logic CMP_KEEP = 1'b1;

endpackage

// File: rtl/sar_settle_timer.sv
// Down-counter that paces DAC settling: load on SETTLE entry, expired after
// SETTLE_CYCLES cycles of counting.
module sar_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation register: resolves N_BITS from the comparator, MSB first.
// Optional DAC settle wait per bit when SAR_SETTLE_EN is defined.
module sar_logic
    import sar_pkg::*;
#(
    parameter int N_BITS        = DEFAULT_N_BITS,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sar_en,
    input  logic              sar_clear,
    input  logic              cmp_i,
    output logic              cmp_latch,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] result,
    output logic              result_valid,
    output logic              sar_done
);

    localparam int IDX_W = $clog2(N_BITS);

    sar_state_t        state, state_nxt;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic [N_BITS-1:0] dac_code_nxt, result_nxt, trial_code;
    logic              result_valid_nxt;
    logic              timer_load;
    logic              timer_expired;

    // Each dac_code update goes through SETTLE when settling is enabled.
    sar_state_t        step_state;

`ifdef SAR_SETTLE_EN
    assign step_state = ST_SETTLE;

    sar_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (timer_load),
        .run     (state == ST_SETTLE),
        .expired (timer_expired)
    );
`else
    assign step_state    = ST_TRIAL;
    assign timer_expired = 1'b1;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            bit_idx      <= '0;
            dac_code     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_idx      <= bit_idx_nxt;
            dac_code     <= dac_code_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        bit_idx_nxt      = bit_idx;
        dac_code_nxt     = dac_code;
        result_nxt       = result;
        result_valid_nxt = 1'b0;
        timer_load       = 1'b0;
        trial_code       = dac_code;

        if (sar_clear) begin
            state_nxt    = ST_IDLE;
            dac_code_nxt = '0;
            bit_idx_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sar_en) begin
                        state_nxt    = step_state;
                        timer_load   = 1'b1;
                        dac_code_nxt = {1'b1, {(N_BITS-1){1'b0}}};
                        bit_idx_nxt  = IDX_W'(N_BITS - 1);
                    end
                end
                ST_SETTLE: begin
                    if (!sar_en) begin
                        state_nxt    = ST_IDLE;
                        dac_code_nxt = '0;
                        bit_idx_nxt  = '0;
                    end else if (timer_expired) begin
                        state_nxt = ST_TRIAL;
                    end
                end
                ST_TRIAL: begin
                    if (!sar_en) begin
                        state_nxt    = ST_IDLE;
                        dac_code_nxt = '0;
                        bit_idx_nxt  = '0;
                    end else begin
                        if (cmp_i != CMP_KEEP) begin
                            trial_code[bit_idx] = 1'b0;
                        end
                        // The last bit ends the conversion; bit_idx never wraps below zero.
                        if (bit_idx != '0) begin
                            trial_code[bit_idx - 1'b1] = 1'b1;
                            bit_idx_nxt = bit_idx - 1'b1;
                            state_nxt   = step_state;
                            timer_load  = 1'b1;
                        end else begin
                            result_nxt       = trial_code;
                            result_valid_nxt = 1'b1;
                            state_nxt        = ST_DONE;
                        end
                        dac_code_nxt = trial_code;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    dac_code_nxt = '0;
                    bit_idx_nxt  = '0;
                end
            endcase
        end
    end

    assign cmp_latch = (state == ST_TRIAL);
    assign sar_done  = (state == ST_DONE);

endmodule

// File: tb/tb_sar_logic.sv
// Directed self-checking bench for sar_logic (default build; SAR_SETTLE_EN adjusts timing
// expectations when defined for the bench as well).
module tb_sar_logic;

    localparam int N_BITS = 16;
`ifdef SAR_SETTLE_EN
    localparam int SETTLE = 2;
    localparam int GAP    = SETTLE + 1;
`else
    localparam int GAP    = 1;
`endif
    localparam int LAT = N_BITS * GAP + 1;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        sar_en = 1'b0;
    logic        sar_clear = 1'b0;
    wire         cmp_i;
    logic        cmp_latch;
    logic [15:0] dac_code;
    logic [15:0] result;
    logic        result_valid;
    logic        sar_done;

    logic [15:0] vin = 16'h0000;
    int          mode = 0;      // 0: ideal comparator, 1: tied 0, 2: tied 1
    logic [15:0] trace [0:63];

    int checks = 0;
    int errors = 0;

    assign cmp_i = (mode == 0) ? (vin >= dac_code) : (mode == 2);

    always #5 clk = ~clk;

    sar_logic dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sar_en       (sar_en),
        .sar_clear    (sar_clear),
        .cmp_i        (cmp_i),
        .cmp_latch    (cmp_latch),
        .dac_code     (dac_code),
        .result       (result),
        .result_valid (result_valid),
        .sar_done     (sar_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one conversion from IDLE, stepping an independent SAR model alongside.
    task automatic run_conv(input string tag, input logic [15:0] vin_in, input int mode_in,
                            input logic [15:0] exp_res);
        logic [15:0] exp_code;
        int          b, done_edge, rv_cnt, latch_cnt, low_run;
        logic        prev_latch, prev_cmp;
        vin = vin_in;
        mode = mode_in;
        exp_code = 16'h8000;
        b = N_BITS - 1;
        done_edge = 0;
        rv_cnt = 0;
        latch_cnt = 0;
        low_run = 0;
        prev_latch = 1'b0;
        prev_cmp = 1'b0;
        @(negedge clk);
        sar_en = 1'b1;
        for (int e = 1; e <= LAT + 3; e++) begin
            @(posedge clk);
            #1;
            if (prev_latch) begin
                if (!prev_cmp) exp_code[b] = 1'b0;
                if (b > 0) begin
                    exp_code[b-1] = 1'b1;
                    b--;
                end
            end
            trace[e] = dac_code;
            check({tag, "_dac_step"}, dac_code, exp_code);
            if (sar_done && done_edge == 0) done_edge = e;
            if (result_valid) rv_cnt++;
            if (cmp_latch) begin
                latch_cnt++;
`ifdef SAR_SETTLE_EN
                check({tag, "_settle_gap"}, low_run, SETTLE);
`endif
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_latch = cmp_latch;
            prev_cmp = cmp_i;
        end
        check({tag, "_done_edge"}, done_edge, LAT);
        check({tag, "_rv_pulses"}, rv_cnt, 1);
        check({tag, "_latch_cycles"}, latch_cnt, N_BITS);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_done_held"}, sar_done, 1'b1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        sar_en = 1'b0;
        sar_clear = 1'b1;
        @(negedge clk);
        sar_clear = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_dac", dac_code, 16'h0000);
        check("rst_result", result, 16'h0000);
        check("rst_flags", {cmp_latch, result_valid, sar_done}, 3'b000);
        #20;
        n_rst = 1'b1;

        // Ideal comparator, plus directed trial steps 0x8000 -> 0xC000 -> 0xA000.
        run_conv("vin_a5c3", 16'hA5C3, 0, 16'hA5C3);
        check("trial_first", trace[1], 16'h8000);
        check("trial_second", trace[1 + GAP], 16'hC000);
        check("trial_third", trace[1 + 2 * GAP], 16'hA000);

        // DONE ignores sar_en low, then clear exits.
        @(negedge clk);
        sar_en = 1'b0;
        repeat (3) @(negedge clk);
        check("done_en_low", sar_done, 1'b1);
        check("done_code_hold", dac_code, 16'hA5C3);
        sar_clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_done", sar_done, 1'b0);
        check("clear_dac", dac_code, 16'h0000);
        check("clear_result_kept", result, 16'hA5C3);
        @(negedge clk);
        sar_clear = 1'b0;

        run_conv("tie0", 16'h0000, 1, 16'h0000);
        do_clear();
        run_conv("tie1", 16'h0000, 2, 16'hFFFF);
        do_clear();
        run_conv("vin_1234", 16'h1234, 0, 16'h1234);
        do_clear();
        run_conv("vin_a5c3_b", 16'hA5C3, 0, 16'hA5C3);
        do_clear();

        // Abort during the fifth TRIAL cycle.
        vin = 16'h3C3C;
        mode = 0;
        @(negedge clk);
        sar_en = 1'b1;
        repeat (5 * GAP) @(posedge clk);
        #1;
        check("abort_in_trial", cmp_latch, 1'b1);
        @(negedge clk);
        sar_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_dac", dac_code, 16'h0000);
        check("abort_flags", {cmp_latch, result_valid, sar_done}, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", sar_done, 1'b0);
        check("abort_result_kept", result, 16'hA5C3);

        // Clear together with sar_en keeps the block in IDLE.
        @(negedge clk);
        sar_en = 1'b1;
        sar_clear = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("clear_en_idle", {cmp_latch, sar_done}, 2'b00);
        check("clear_en_dac", dac_code, 16'h0000);

        // Async reset mid-TRIAL.
        @(negedge clk);
        sar_clear = 1'b0;
        repeat (4 * GAP) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("areset_dac", dac_code, 16'h0000);
        check("areset_result", result, 16'h0000);
        check("areset_flags", {cmp_latch, result_valid, sar_done}, 3'b000);
        @(negedge clk);
        sar_en = 1'b0;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", {cmp_latch, sar_done}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
